// File: rtl/reg_status_pkg.sv
// Shared constants and helpers for the register status table.
// The optional REG_STATUS_CDB_BYPASS_EN build is handled in reg_status_multi.
package reg_status_pkg;

    localparam int TAG_READY    = 0;
    localparam int DEF_NUM_REGS = 32;
    localparam int DEF_TAG_W    = 5;
    localparam int DEF_DATA_W   = 32;
    localparam int DEF_NUM_RD   = 2;
    localparam int DEF_NUM_CDB  = 2;
    localparam int CDB_MAX_W    = 32;

    // Index of the lowest requesting CDB channel, -1 when none requests.
    function automatic int first_hit(input logic [CDB_MAX_W-1:0] req);
        first_hit = -1;
        for (int i = CDB_MAX_W - 1; i >= 0; i--) begin
            if (req[i]) first_hit = i;
        end
    endfunction

endpackage

// File: rtl/reg_status_cdb_snoop.sv
// Matches one producer tag against every CDB channel; the lowest-index
// matching channel supplies the value. A ready tag never hits.
module reg_status_cdb_snoop
    import reg_status_pkg::*;
#(
    parameter int TAG_W   = DEF_TAG_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int NUM_CDB = DEF_NUM_CDB
) (
    input  logic [TAG_W-1:0]          tag,
    input  logic [NUM_CDB-1:0]        cdb_valid,
    input  logic [NUM_CDB*TAG_W-1:0]  cdb_tag,
    input  logic [NUM_CDB*DATA_W-1:0] cdb_val,
    output logic                      hit,
    output logic [DATA_W-1:0]         val
);

    logic [NUM_CDB-1:0] match;
    int                 sel;

    always_comb begin
        match = '0;
        for (int c = 0; c < NUM_CDB; c++) begin
            match[c] = cdb_valid[c] && (cdb_tag[c*TAG_W +: TAG_W] == tag);
        end
        hit = (tag != TAG_W'(TAG_READY)) && (match != '0);
        sel = first_hit(CDB_MAX_W'(match));
        val = '0;
        for (int c = 0; c < NUM_CDB; c++) begin
            if (sel == c) val = cdb_val[c*DATA_W +: DATA_W];
        end
    end

endmodule

// File: rtl/reg_status_multi.sv
// Tomasulo register status table: NUM_RD lookups, one rename, NUM_CDB snoops.
// Define REG_STATUS_CDB_BYPASS_EN to forward same-cycle CDB results to lookups.
module reg_status_multi
    import reg_status_pkg::*;
#(
    parameter  int NUM_REGS = DEF_NUM_REGS,
    localparam int REG_W    = $clog2(NUM_REGS),
    parameter  int TAG_W    = DEF_TAG_W,
    parameter  int DATA_W   = DEF_DATA_W,
    parameter  int NUM_RD   = DEF_NUM_RD,
    parameter  int NUM_CDB  = DEF_NUM_CDB
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_issue_valid,
    input  logic [NUM_RD*REG_W-1:0]   in_src_reg,
    input  logic                      in_dest_en,
    input  logic [REG_W-1:0]          in_dest_reg,
    input  logic [TAG_W-1:0]          in_dest_tag,
    input  logic [NUM_CDB-1:0]        in_cdb_valid,
    input  logic [NUM_CDB*TAG_W-1:0]  in_cdb_tag,
    input  logic [NUM_CDB*DATA_W-1:0] in_cdb_val,
    input  logic                      in_flush,
    output logic                      out_valid,
    output logic [NUM_RD*DATA_W-1:0]  out_val,
    output logic [NUM_RD*TAG_W-1:0]   out_tag,
    output logic [REG_W:0]            out_pending_cnt
);

    localparam int CNT_W = REG_W + 1;

    // Handshake: no back-pressure; an issue is accepted every cycle
    // in_issue_valid is high and its lookup appears with out_valid one cycle later.

    logic [DATA_W-1:0] val_q [NUM_REGS];
    logic [TAG_W-1:0]  tag_q [NUM_REGS];
    logic [DATA_W-1:0] val_n [NUM_REGS];
    logic [TAG_W-1:0]  tag_n [NUM_REGS];
    logic [NUM_REGS-1:0] ent_hit;
    logic [DATA_W-1:0]   ent_val [NUM_REGS];
    logic [CNT_W-1:0]    cnt_n;
    logic                rename;

    logic [TAG_W-1:0]  rd_tag_raw [NUM_RD];
    logic [DATA_W-1:0] rd_val_raw [NUM_RD];
    logic [TAG_W-1:0]  rd_tag     [NUM_RD];
    logic [DATA_W-1:0] rd_val     [NUM_RD];

    for (genvar e = 0; e < NUM_REGS; e++) begin : g_ent
        reg_status_cdb_snoop #(
            .TAG_W  (TAG_W),
            .DATA_W (DATA_W),
            .NUM_CDB(NUM_CDB)
        ) u_snoop (
            .tag      (tag_q[e]),
            .cdb_valid(in_cdb_valid),
            .cdb_tag  (in_cdb_tag),
            .cdb_val  (in_cdb_val),
            .hit      (ent_hit[e]),
            .val      (ent_val[e])
        );
    end

    // Priority per entry: flush > rename > CDB for the tag; a rename keeps the
    // old value, while a flush still lets the CDB write land.
    always_comb begin
        rename = in_issue_valid && in_dest_en && !in_flush
                 && (in_dest_tag != TAG_W'(TAG_READY));
        cnt_n  = '0;
        for (int e = 0; e < NUM_REGS; e++) begin
            val_n[e] = val_q[e];
            tag_n[e] = tag_q[e];
            if (ent_hit[e]) begin
                val_n[e] = ent_val[e];
                tag_n[e] = TAG_W'(TAG_READY);
            end
            if (rename && (in_dest_reg == REG_W'(e))) begin
                val_n[e] = val_q[e];
                tag_n[e] = in_dest_tag;
            end
            if (in_flush) tag_n[e] = TAG_W'(TAG_READY);
        end
        val_n[0] = '0;
        tag_n[0] = TAG_W'(TAG_READY);
        for (int e = 0; e < NUM_REGS; e++) begin
            cnt_n = cnt_n + CNT_W'(tag_n[e] != TAG_W'(TAG_READY));
        end
    end

    always_comb begin
        for (int p = 0; p < NUM_RD; p++) begin
            rd_tag_raw[p] = tag_q[in_src_reg[p*REG_W +: REG_W]];
            rd_val_raw[p] = val_q[in_src_reg[p*REG_W +: REG_W]];
        end
    end

`ifdef REG_STATUS_CDB_BYPASS_EN
    logic [NUM_RD-1:0] byp_hit;
    logic [DATA_W-1:0] byp_val [NUM_RD];

    for (genvar p = 0; p < NUM_RD; p++) begin : g_byp
        reg_status_cdb_snoop #(
            .TAG_W  (TAG_W),
            .DATA_W (DATA_W),
            .NUM_CDB(NUM_CDB)
        ) u_byp (
            .tag      (rd_tag_raw[p]),
            .cdb_valid(in_cdb_valid),
            .cdb_tag  (in_cdb_tag),
            .cdb_val  (in_cdb_val),
            .hit      (byp_hit[p]),
            .val      (byp_val[p])
        );
    end

    always_comb begin
        for (int p = 0; p < NUM_RD; p++) begin
            rd_tag[p] = byp_hit[p] ? TAG_W'(TAG_READY) : rd_tag_raw[p];
            rd_val[p] = byp_hit[p] ? byp_val[p] : rd_val_raw[p];
        end
    end
`else
    always_comb begin
        for (int p = 0; p < NUM_RD; p++) begin
            rd_tag[p] = rd_tag_raw[p];
            rd_val[p] = rd_val_raw[p];
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int e = 0; e < NUM_REGS; e++) begin
                val_q[e] <= '0;
                tag_q[e] <= '0;
            end
            out_valid       <= 1'b0;
            out_val         <= '0;
            out_tag         <= '0;
            out_pending_cnt <= '0;
        end else begin
            for (int e = 0; e < NUM_REGS; e++) begin
                val_q[e] <= val_n[e];
                tag_q[e] <= tag_n[e];
            end
            out_valid       <= in_issue_valid;
            out_pending_cnt <= cnt_n;
            if (in_issue_valid) begin
                for (int p = 0; p < NUM_RD; p++) begin
                    out_val[p*DATA_W +: DATA_W] <= rd_val[p];
                    out_tag[p*TAG_W +: TAG_W]   <= rd_tag[p];
                end
            end
        end
    end

endmodule

// File: tb/tb_reg_status_multi.sv
// Randomized scoreboard bench for reg_status_multi against a behavioural model.
module tb_reg_status_multi;

    localparam int NR  = 32;
    localparam int RW  = 5;
    localparam int TW  = 5;
    localparam int DW  = 32;
    localparam int NRD = 2;
    localparam int NC  = 2;
    localparam int LK_W = NRD * (DW + TW);
`ifdef REG_STATUS_CDB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_issue_valid = 1'b0;
    logic [NRD*RW-1:0] in_src_reg = '0;
    logic              in_dest_en = 1'b0;
    logic [RW-1:0]     in_dest_reg = '0;
    logic [TW-1:0]     in_dest_tag = '0;
    logic [NC-1:0]     in_cdb_valid = '0;
    logic [NC*TW-1:0]  in_cdb_tag = '0;
    logic [NC*DW-1:0]  in_cdb_val = '0;
    logic              in_flush = 1'b0;
    logic              out_valid;
    logic [NRD*DW-1:0] out_val;
    logic [NRD*TW-1:0] out_tag;
    logic [RW:0]       out_pending_cnt;

    reg_status_multi dut (
        .clk            (clk),
        .rst            (rst),
        .in_issue_valid (in_issue_valid),
        .in_src_reg     (in_src_reg),
        .in_dest_en     (in_dest_en),
        .in_dest_reg    (in_dest_reg),
        .in_dest_tag    (in_dest_tag),
        .in_cdb_valid   (in_cdb_valid),
        .in_cdb_tag     (in_cdb_tag),
        .in_cdb_val     (in_cdb_val),
        .in_flush       (in_flush),
        .out_valid      (out_valid),
        .out_val        (out_val),
        .out_tag        (out_tag),
        .out_pending_cnt(out_pending_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [LK_W-1:0] exp_q[$];
    logic [RW+1:0]   cyc_q[$];

    logic [DW-1:0] ref_val [NR];
    logic [TW-1:0] ref_tag [NR];

    logic              d_issue, d_den, d_flush;
    logic [NRD*RW-1:0] d_src;
    logic [RW-1:0]     d_dest;
    logic [TW-1:0]     d_dtag;
    logic [NC-1:0]     d_cdbv;
    logic [NC*TW-1:0]  d_cdbt;
    logic [NC*DW-1:0]  d_cdbd;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < NR; r++) begin
            ref_val[r] = '0;
            ref_tag[r] = '0;
        end
        exp_q.delete();
        cyc_q.delete();
    endtask

    task automatic clr();
        d_issue = 0; d_den = 0; d_flush = 0; d_src = '0; d_dest = '0;
        d_dtag = '0; d_cdbv = '0; d_cdbt = '0; d_cdbd = '0;
    endtask

    task automatic set_cdb(input int c, input int t, input int v);
        d_cdbv[c] = 1'b1;
        d_cdbt[c*TW +: TW] = TW'(t);
        d_cdbd[c*DW +: DW] = DW'(v);
    endtask

    // Drive one cycle (called at a falling edge), predict its results, advance the model.
    task automatic step();
        logic [DW-1:0] nv [NR];
        logic [TW-1:0] nt [NR];
        logic [NRD*DW-1:0] lv;
        logic [NRD*TW-1:0] lt;
        int cnt;
        in_issue_valid = d_issue; in_src_reg = d_src; in_dest_en = d_den;
        in_dest_reg = d_dest; in_dest_tag = d_dtag; in_cdb_valid = d_cdbv;
        in_cdb_tag = d_cdbt; in_cdb_val = d_cdbd; in_flush = d_flush;
        for (int p = 0; p < NRD; p++) begin
            int r;
            logic [DW-1:0] v;
            logic [TW-1:0] t;
            bit done;
            r = int'(d_src[p*RW +: RW]);
            v = ref_val[r];
            t = ref_tag[r];
            done = 0;
            if (BYP && t != 0) begin
                for (int c = 0; c < NC; c++) begin
                    if (!done && d_cdbv[c] && d_cdbt[c*TW +: TW] == t) begin
                        v = d_cdbd[c*DW +: DW];
                        t = '0;
                        done = 1;
                    end
                end
            end
            lv[p*DW +: DW] = v;
            lt[p*TW +: TW] = t;
        end
        if (d_issue) exp_q.push_back({lv, lt});
        for (int r = 0; r < NR; r++) begin
            nv[r] = ref_val[r];
            nt[r] = ref_tag[r];
        end
        for (int r = 1; r < NR; r++) begin
            bit done;
            done = 0;
            if (ref_tag[r] != 0) begin
                for (int c = 0; c < NC; c++) begin
                    if (!done && d_cdbv[c] && d_cdbt[c*TW +: TW] == ref_tag[r]) begin
                        nv[r] = d_cdbd[c*DW +: DW];
                        nt[r] = '0;
                        done = 1;
                    end
                end
            end
        end
        if (d_issue && d_den && d_dtag != 0 && !d_flush && d_dest != 0) begin
            nt[d_dest] = d_dtag;
            nv[d_dest] = ref_val[d_dest];
        end
        cnt = 0;
        for (int r = 0; r < NR; r++) begin
            if (d_flush) nt[r] = '0;
            if (nt[r] != 0) cnt++;
            ref_val[r] = nv[r];
            ref_tag[r] = nt[r];
        end
        cyc_q.push_back({d_issue, (RW+1)'(cnt)});
        @(negedge clk);
    endtask

    task automatic do_rename(input int r, input int t);
        clr(); d_issue = 1; d_den = 1; d_dest = RW'(r); d_dtag = TW'(t);
        step();
    endtask

    task automatic do_read(input int a, input int b);
        clr(); d_issue = 1; d_src = {RW'(b), RW'(a)};
        step();
    endtask

    // Monitor: pops per-cycle expectations and the held lookup result.
    initial begin
        logic [LK_W-1:0] last_exp;
        logic [RW+1:0]   e;
        last_exp = '0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                last_exp = '0;
                continue;
            end
            if (cyc_q.size() == 0) continue;
            e = cyc_q.pop_front();
            check("valid", 64'(out_valid), 64'(e[RW+1]));
            check("pending_cnt", 64'(out_pending_cnt), 64'(e[RW:0]));
            if (e[RW+1]) begin
                if (exp_q.size() == 0) check("lookup_queue_underflow", 64'(1), 64'(0));
                else last_exp = exp_q.pop_front();
            end
            check("out_val", 64'(out_val), 64'(last_exp[LK_W-1:NRD*TW]));
            check("out_tag", 64'(out_tag), 64'(last_exp[NRD*TW-1:0]));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not end");
        $fatal(1, "timeout");
    end

    initial begin
        clr();
        model_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_valid", 64'(out_valid), 64'(0));
        check("reset_cnt", 64'(out_pending_cnt), 64'(0));
        rst = 1'b0;

        // Reset while a producer is pending, asserted mid-cycle.
        do_rename(5, 1);
        do_read(5, 0);
        clr(); step();
        #2 rst = 1'b1;
        #1;
        check("async_rst_valid", 64'(out_valid), 64'(0));
        check("async_rst_val", 64'(out_val), 64'(0));
        check("async_rst_tag", 64'(out_tag), 64'(0));
        check("async_rst_cnt", 64'(out_pending_cnt), 64'(0));
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        do_read(5, 0);

        // Rename then CDB completion.
        do_rename(5, 1);
        do_read(5, 0);
        clr(); set_cdb(0, 1, 7); step();
        do_read(5, 0);

        // Dual CDB, distinct tags, then same tag on both channels.
        do_rename(3, 2);
        do_rename(4, 3);
        clr(); set_cdb(0, 3, 9); set_cdb(1, 2, 4); step();
        do_read(3, 4);
        do_rename(3, 2);
        clr(); set_cdb(0, 2, 5); set_cdb(1, 2, 6); step();
        do_read(3, 4);

        // Rename collides with CDB completion on the same entry.
        do_rename(6, 4);
        clr(); d_issue = 1; d_den = 1; d_dest = 5'd6; d_dtag = 5'd7; set_cdb(0, 4, 11); step();
        do_read(6, 0);

        // Flush with a concurrent rename; writes to r0 are ignored.
        do_rename(1, 1);
        do_rename(2, 2);
        clr(); d_issue = 1; d_den = 1; d_dest = 5'd7; d_dtag = 5'd5; d_flush = 1; step();
        do_read(7, 1);
        do_rename(0, 3);
        do_read(0, 2);

        // Same-cycle lookup and broadcast of the source's producer.
        do_rename(5, 1);
        clr(); d_issue = 1; d_src = {5'd0, 5'd5}; set_cdb(0, 1, 7); step();
        do_read(5, 0);

        // Randomized traffic with a narrow tag range to force collisions.
        for (int i = 0; i < 500; i++) begin
            clr();
            d_issue = 1'($urandom_range(0, 3) != 0);
            for (int p = 0; p < NRD; p++) begin
                d_src[p*RW +: RW] = RW'($urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom_range(0, NR - 1));
            end
            d_den = 1'($urandom_range(0, 1));
            d_dest = RW'($urandom_range(0, 7));
            d_dtag = TW'($urandom_range(0, 7));
            for (int c = 0; c < NC; c++) begin
                if ($urandom_range(0, 1) == 1) set_cdb(c, $urandom_range(0, 7), $urandom);
            end
            d_flush = 1'($urandom_range(0, 24) == 0);
            step();
        end

        clr(); step();
        @(negedge clk);
        @(negedge clk);
        check("cycle_queue_drained", 64'(cyc_q.size()), 64'(0));
        check("lookup_queue_drained", 64'(exp_q.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
